// File: rtl/lcd_timing_driver_if.sv
// Coordinate-to-pixel request bus plus the panel pin bundle of the LCD timing driver.
// The driver is the master: it issues coordinates and drives the pins; the pixel generator is the slave.
interface lcd_timing_driver_if;
  logic [23:0] lcd_data;
  logic        lcd_request;
  logic [11:0] lcd_xpos;
  logic [11:0] lcd_ypos;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic        frame_start;

  modport master (
    input  lcd_data,
    output lcd_request, lcd_xpos, lcd_ypos,
    output lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
  );

  modport slave (
    output lcd_data,
    input  lcd_request, lcd_xpos, lcd_ypos,
    input  lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
  );
endinterface

// File: rtl/lcd_timing_driver.sv
// Raster timing generator for the LCD/VGA port: requests pixels by coordinate and re-aligns
// sync/enable with the returned RGB so the pin raster is the raw raster delayed by DATA_LAT+1 clocks.
module lcd_timing_driver #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int DATA_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  lcd_timing_driver_if.master lcd
);

  localparam logic [11:0] H_TOTAL   = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_BEG = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_END = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] V_TOTAL   = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [11:0] V_SYNC_W  = 12'(V_SYNC);
  localparam logic [11:0] V_ACT_BEG = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_END = 12'(V_SYNC + V_BACK + V_DISP);

  typedef struct packed {
    logic hs;
    logic vs;
    logic req;
    logic first;
  } tap_t;

  localparam tap_t TAP_IDLE = '{hs: 1'b1, vs: 1'b1, req: 1'b0, first: 1'b0};

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_act;
  logic        v_act;
  logic        request;
  logic [11:0] xpos;
  logic [11:0] ypos;
  tap_t        tap_in;
  tap_t        tap_out;
  tap_t        pipe [DATA_LAT];

  logic        hs_q;
  logic        vs_q;
  logic        de_q;
  logic        fs_q;
  logic [23:0] rgb_q;

  // v_cnt advances only on the h_cnt wrap, so both wrap together at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 12'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_comb begin
    h_act   = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_act   = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    request = h_act && v_act;
    xpos    = request ? h_cnt - H_ACT_BEG : 12'd0;
    ypos    = request ? v_cnt - V_ACT_BEG : 12'd0;
    tap_in.hs    = (h_cnt >= H_SYNC_W);
    tap_in.vs    = (v_cnt >= V_SYNC_W);
    tap_in.req   = request;
    tap_in.first = request && (xpos == 12'd0) && (ypos == 12'd0);
  end

  // Delay line matching the pixel generator latency; reset leaves it in the idle raster state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_LAT; i++) pipe[i] <= TAP_IDLE;
    end else begin
      pipe[0] <= tap_in;
      for (int i = 1; i < DATA_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tap_out = pipe[DATA_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= tap_out.hs;
      vs_q  <= tap_out.vs;
      de_q  <= tap_out.req;
      fs_q  <= tap_out.first;
      rgb_q <= tap_out.req ? lcd.lcd_data : 24'h0;
    end
  end

  assign lcd.lcd_request = request;
  assign lcd.lcd_xpos    = xpos;
  assign lcd.lcd_ypos    = ypos;
  assign lcd.lcd_hs      = hs_q;
  assign lcd.lcd_vs      = vs_q;
  assign lcd.lcd_de      = de_q;
  assign lcd.lcd_rgb     = rgb_q;
  assign lcd.frame_start = fs_q;

endmodule
